host_link_fsm: RTL

Parametrised host-link controller for the downsampling platform. It is the successor to the fixed UART loader: byte-level UART receive/transmit on one side, and on the other `NUM_CH` loadable byte memories plus the processor START/END handshake. It takes commands with explicit length and channel, so instruction, image and future memories load through one path. It also adds memory read-back (DUMP) and an error response, which the previous loader lacked.

---
 rtl/host_link_pkg.sv | 31 +++
 rtl/host_link_fsm.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/host_link_pkg.sv
// Shared definitions for the host-link controller: opcodes, response bytes,
// controller state encoding and the result-count byte helper.
package host_link_pkg;

   localparam logic [1:0] OP_LOAD = 2'b00;
   localparam logic [1:0] OP_RUN  = 2'b01;
   localparam logic [1:0] OP_DUMP = 2'b10;

   localparam logic [7:0] RSP_ACK  = 8'hA5;
   localparam logic [7:0] RSP_DONE = 8'hD0;
   localparam logic [7:0] RSP_ERR  = 8'hEE;

   typedef enum logic [3:0] {
      S_IDLE,
      S_LEN,
      S_LOAD_DATA,
      S_ACK,
      S_RUN_WAIT,
      S_RPT,
      S_DUMP_RD,
      S_DUMP_WAIT,
      S_DUMP_TX,
      S_ERR
   } state_t;

   // Number of bytes needed to carry a w-bit value.
   function automatic int count_bytes(input int w);
      return (w + 7) / 8;
   endfunction

endpackage

// File: rtl/host_link_fsm.sv
// Host-link controller: decodes LOAD / RUN / DUMP commands from the UART byte
// stream, loads or reads back the attached byte memories, drives the processor
// START/END handshake and returns response bytes over the TX byte interface.
module host_link_fsm
   import host_link_pkg::*;
#(
   parameter int ADDR_WIDTH = 19,
   parameter int NUM_CH     = 2,
   parameter int LEN_BYTES  = 3
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    rx_valid,
   input  logic [7:0]              rx_data,
   output logic                    tx_valid,
   output logic [7:0]              tx_data,
   input  logic                    tx_ready,
   output logic [ADDR_WIDTH-1:0]   mem_addr,
   output logic [7:0]              mem_wdata,
   output logic [NUM_CH-1:0]       mem_we,
   output logic [NUM_CH-1:0]       mem_re,
   input  logic [8*NUM_CH-1:0]     mem_rdata,
   output logic                    start_flag,
   input  logic                    end_flag,
   input  logic [ADDR_WIDTH-1:0]   result_count,
   output logic                    busy,
   output logic                    err_led
);

   localparam int LW = 8 * LEN_BYTES;                       // length arithmetic width
   localparam int CB = count_bytes(ADDR_WIDTH);             // result-count bytes
   localparam int RW = 8 * CB;
   localparam int TW = RW + 8;                              // TX shifter: DONE + count
   localparam int CW = (LW > ADDR_WIDTH + 1) ? LW : ADDR_WIDTH + 1;
   localparam int IW = $clog2(LEN_BYTES + 1);
   localparam int SW = $clog2(CB + 2);

   state_t                  state_reg, state_next;
   logic [1:0]              op_reg, op_next;
   logic [5:0]              ch_reg, ch_next;
   logic [IW-1:0]           idx_reg, idx_next;
   logic [LW-1:0]           len_reg, len_next;        // length, then bytes remaining
   logic [ADDR_WIDTH-1:0]   addr_reg, addr_next;      // running memory address
   logic [ADDR_WIDTH-1:0]   waddr_reg, waddr_next;
   logic [7:0]              wdata_reg, wdata_next;
   logic [NUM_CH-1:0]       we_reg, we_next;
   logic [TW-1:0]           tx_sr_reg, tx_sr_next;
   logic [SW-1:0]           txcnt_reg, txcnt_next;
   logic                    err_reg, err_next;

   logic [LW-1:0]           len_full;
   logic                    too_big;
   logic [7:0]              rd_byte;
   logic [NUM_CH-1:0]       ch_onehot;

   // Length with the current byte merged in, LSB-first.
   assign len_full  = len_reg | (LW'(rx_data) << {idx_reg, 3'b000});
   assign too_big   = CW'(len_full) > (CW'(1) << ADDR_WIDTH);
   assign rd_byte   = 8'(mem_rdata >> {ch_reg, 3'b000});
   assign ch_onehot = NUM_CH'(1) << ch_reg;

   // State and datapath registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_reg <= S_IDLE;
         op_reg    <= '0;
         ch_reg    <= '0;
         idx_reg   <= '0;
         len_reg   <= '0;
         addr_reg  <= '0;
         waddr_reg <= '0;
         wdata_reg <= '0;
         we_reg    <= '0;
         tx_sr_reg <= '0;
         txcnt_reg <= '0;
         err_reg   <= 1'b0;
      end else begin
         state_reg <= state_next;
         op_reg    <= op_next;
         ch_reg    <= ch_next;
         idx_reg   <= idx_next;
         len_reg   <= len_next;
         addr_reg  <= addr_next;
         waddr_reg <= waddr_next;
         wdata_reg <= wdata_next;
         we_reg    <= we_next;
         tx_sr_reg <= tx_sr_next;
         txcnt_reg <= txcnt_next;
         err_reg   <= err_next;
      end
   end

   // Next-state and datapath updates for the command sequencer.
   always_comb begin
      state_next = state_reg;
      op_next    = op_reg;
      ch_next    = ch_reg;
      idx_next   = idx_reg;
      len_next   = len_reg;
      addr_next  = addr_reg;
      waddr_next = waddr_reg;
      wdata_next = wdata_reg;
      we_next    = '0;
      tx_sr_next = tx_sr_reg;
      txcnt_next = txcnt_reg;
      err_next   = err_reg;

      case (state_reg)
         S_IDLE: begin
            addr_next = '0;
            idx_next  = '0;
            len_next  = '0;
            if (rx_valid) begin
               op_next = rx_data[7:6];
               ch_next = rx_data[5:0];
               if (rx_data[7:6] == OP_RUN) begin
                  state_next = S_RUN_WAIT;
               end else if ((rx_data[7:6] == OP_LOAD || rx_data[7:6] == OP_DUMP) &&
                            ({1'b0, rx_data[5:0]} < 7'(NUM_CH))) begin
                  state_next = S_LEN;
               end else begin
                  state_next = S_ERR;
                  err_next   = 1'b1;
               end
            end
         end
         S_LEN: begin
            if (rx_valid) begin
               len_next = len_full;
               idx_next = idx_reg + IW'(1);
               if (idx_reg == IW'(LEN_BYTES - 1)) begin
                  if (too_big) begin
                     state_next = S_ERR;
                     err_next   = 1'b1;
                  end else if (len_full == '0) begin
                     state_next = S_ACK;
                  end else if (op_reg == OP_LOAD) begin
                     state_next = S_LOAD_DATA;
                  end else begin
                     state_next = S_DUMP_RD;
                  end
               end
            end
         end
         S_LOAD_DATA: begin
            if (rx_valid) begin
               we_next    = ch_onehot;
               waddr_next = addr_reg;
               wdata_next = rx_data;
               addr_next  = addr_reg + ADDR_WIDTH'(1);
               len_next   = len_reg - LW'(1);
               if (len_reg == LW'(1)) state_next = S_ACK;
            end
         end
         S_ACK, S_ERR: begin
            if (tx_ready) state_next = S_IDLE;
         end
         S_RUN_WAIT: begin
            if (end_flag) begin
               tx_sr_next = {RW'(result_count), RSP_DONE};
               txcnt_next = SW'(CB + 1);
               state_next = S_RPT;
            end
         end
         S_RPT: begin
            if (tx_ready) begin
               tx_sr_next = tx_sr_reg >> 8;
               txcnt_next = txcnt_reg - SW'(1);
               if (txcnt_reg == SW'(1)) state_next = S_IDLE;
            end
         end
         S_DUMP_RD: begin
            state_next = S_DUMP_WAIT;
         end
         S_DUMP_WAIT: begin
            tx_sr_next = TW'(rd_byte);
            state_next = S_DUMP_TX;
         end
         S_DUMP_TX: begin
            // Address only moves once the byte has left.
            if (tx_ready) begin
               addr_next = addr_reg + ADDR_WIDTH'(1);
               len_next  = len_reg - LW'(1);
               state_next = (len_reg == LW'(1)) ? S_ACK : S_DUMP_RD;
            end
         end
         default: state_next = S_IDLE;
      endcase

      // Bytes arriving while the controller cannot take them are dropped and flagged.
      if (rx_valid && !(state_reg inside {S_IDLE, S_LEN, S_LOAD_DATA})) err_next = 1'b1;
   end

   // TX byte selection; depends only on registered state, never on tx_ready.
   always_comb begin
      case (state_reg)
         S_ACK:   tx_data = RSP_ACK;
         S_ERR:   tx_data = RSP_ERR;
         default: tx_data = tx_sr_reg[7:0];
      endcase
   end

   assign tx_valid   = state_reg inside {S_ACK, S_ERR, S_RPT, S_DUMP_TX};
   assign mem_re     = (state_reg == S_DUMP_RD) ? ch_onehot : '0;
   assign mem_addr   = (state_reg == S_DUMP_RD) ? addr_reg : waddr_reg;
   assign mem_wdata  = wdata_reg;
   assign mem_we     = we_reg;
   assign start_flag = (state_reg == S_RUN_WAIT);
   assign busy       = (state_reg != S_IDLE);
   assign err_led    = err_reg;

endmodule
